// File: rtl/systolic_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : systolic_pkg                                              |
// | Description : Shared types and constants for the systolic operand       |
// |               feeder: array geometry, operand type, feeder FSM state    |
// |               encoding, bank-select encodings and a lane slice helper.  |
// | Ports       : none (package)                                            |
// | Revision    : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
package systolic_pkg;

  localparam int N  = 4;
  localparam int DW = 32;

  typedef logic [DW-1:0] operand_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } feeder_state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Extract lane 'lane' (bits lane*DW +: DW) from an N-lane operand bus.
  function automatic operand_t lane_slice(input logic [N*DW-1:0] bus,
                                          input int unsigned     lane);
    return operand_t'(bus >> (lane * DW));
  endfunction

endpackage
`default_nettype wire

// File: rtl/operand_bank.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : operand_bank                                              |
// | Description : NxN register file of DW-bit operands. One synchronous     |
// |               write port, N independent combinational read ports. A     |
// |               read port whose valid flag is low returns exact zero.     |
// |               Contents are deliberately not reset.                      |
// | Ports       : clk                   - clock                             |
// |               wr_en/wr_row/wr_col   - write strobe and address          |
// |               wr_data               - write data                        |
// |               rd_row/rd_col         - N packed read addresses           |
// |               rd_valid              - per-port valid, low forces zero   |
// |               rd_data               - N packed read data lanes          |
// | Revision    : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
module operand_bank #(
  parameter int N  = 4,
  parameter int DW = 32
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic [$clog2(N)-1:0]      wr_row,
  input  logic [$clog2(N)-1:0]      wr_col,
  input  logic [DW-1:0]             wr_data,
  input  logic [N*$clog2(N)-1:0]    rd_row,
  input  logic [N*$clog2(N)-1:0]    rd_col,
  input  logic [N-1:0]              rd_valid,
  output logic [N*DW-1:0]           rd_data
);
  import systolic_pkg::*;

  localparam int c_addr_w = $clog2(N);

  logic [DW-1:0] mem_q [N][N];
  logic [DW-1:0] mem_d [N][N];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_row][wr_col] = wr_data;
    end
  end

  // No reset: operands survive a controller reset so a restart replays them.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  for (genvar p = 0; p < N; p++) begin : g_rd
    logic [c_addr_w-1:0] w_row;
    logic [c_addr_w-1:0] w_col;
    assign w_row = rd_row[p*c_addr_w +: c_addr_w];
    assign w_col = rd_col[p*c_addr_w +: c_addr_w];
    assign rd_data[p*DW +: DW] = rd_valid[p] ? mem_q[w_row][w_col] : '0;
  end

endmodule
`default_nettype wire

// File: rtl/systolic_skew_feeder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : systolic_skew_feeder                                      |
// | Description : Upstream stage of the NxN systolic MAC array. Holds A     |
// |               (west) and B (north) operand banks, and on start emits a  |
// |               one-cycle accumulator clear, 2N-1 diagonally skewed       |
// |               wavefronts, DRAIN_CYCLES zero cycles, then a done pulse.  |
// |               All outputs are registered.                               |
// | Option      : SYSTOLIC_SKEW_FEEDER_TRANSPOSE_B_EN - when defined the B  |
// |               bank is read transposed (north lane j = B[j][t-j]).       |
// | Ports       : clk, rst (async, active-high)                             |
// |               wr_en/wr_sel/wr_row/wr_col/wr_data - operand load port    |
// |               start      - launch pulse (accepted in IDLE only)         |
// |               busy       - high from accepted start until done          |
// |               wr_err     - pulse: write attempted while not idle        |
// |               arr_clr    - one-cycle accumulator clear                  |
// |               feed_valid - west_out/north_out carry wavefront data      |
// |               west_out   - lane i feeds array row i                     |
// |               north_out  - lane j feeds array column j                  |
// |               done       - one-cycle completion pulse                   |
// | Revision    : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
module systolic_skew_feeder #(
  parameter int N            = 4,
  parameter int DW           = 32,
  parameter int DRAIN_CYCLES = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  wr_sel,
  input  logic [$clog2(N)-1:0]  wr_row,
  input  logic [$clog2(N)-1:0]  wr_col,
  input  logic [DW-1:0]         wr_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  wr_err,
  output logic                  arr_clr,
  output logic                  feed_valid,
  output logic [N*DW-1:0]       west_out,
  output logic [N*DW-1:0]       north_out,
  output logic                  done
);
  import systolic_pkg::*;

  localparam int c_addr_w = $clog2(N);
  // Shared by FEED (0..2N-2) and DRAIN (0..DRAIN_CYCLES-1) counting.
  localparam int c_step_w = ($clog2(2*N) > $clog2(DRAIN_CYCLES)) ?
                            $clog2(2*N) : $clog2(DRAIN_CYCLES);
  localparam logic [c_step_w-1:0] c_feed_last  = c_step_w'(2*N - 2);
  localparam logic [c_step_w-1:0] c_drain_last = c_step_w'(DRAIN_CYCLES - 1);

  feeder_state_e         state_q, state_d;
  logic [c_step_w-1:0]   step_q, step_d;
  logic                  busy_q, busy_d;
  logic                  wr_err_q, wr_err_d;
  logic                  arr_clr_q, arr_clr_d;
  logic                  feed_valid_q, feed_valid_d;
  logic                  done_q, done_d;
  logic [N*DW-1:0]       west_q, west_d;
  logic [N*DW-1:0]       north_q, north_d;

  logic                  w_idle;
  logic                  w_a_we;
  logic                  w_b_we;
  logic [N-1:0]          w_lane_vld;
  logic [N*c_addr_w-1:0] w_a_rd_row;
  logic [N*c_addr_w-1:0] w_a_rd_col;
  logic [N*c_addr_w-1:0] w_b_rd_row;
  logic [N*c_addr_w-1:0] w_b_rd_col;
  logic [N*DW-1:0]       w_a_rd_data;
  logic [N*DW-1:0]       w_b_rd_data;

  assign w_idle = (state_q == IDLE);
  assign w_a_we = wr_en && w_idle && (wr_sel == SEL_A);
  assign w_b_we = wr_en && w_idle && (wr_sel == SEL_B);

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          step_d  = '0;
        end
      end
      CLEAR: begin
        state_d = FEED;
        step_d  = '0;
      end
      FEED: begin
        if (step_q == c_feed_last) begin
          state_d = DRAIN;
          step_d  = '0;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      DRAIN: begin
        if (step_q == c_drain_last) begin
          state_d = DONE;
          step_d  = '0;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        step_d  = '0;
      end
      default: begin
        state_d = IDLE;
        step_d  = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so each registered value lines
  // up with the cycle the FSM spends in that state.
  always_comb begin
    busy_d       = (state_d == CLEAR) || (state_d == FEED) || (state_d == DRAIN);
    arr_clr_d    = (state_d == CLEAR);
    feed_valid_d = (state_d == FEED);
    done_d       = (state_d == DONE);
    wr_err_d     = wr_en && !w_idle;
    west_d       = w_a_rd_data;
    north_d      = w_b_rd_data;
  end

  // ------------------------------------------------- skew index generation
  // Lane l at step t carries inner index k = t - l. Computed one bit wider
  // than the step so t < l wraps to a large value and fails the k < N test.
  for (genvar l = 0; l < N; l++) begin : g_lane
    logic [c_step_w:0] w_k;
    assign w_k           = {1'b0, step_d} - (c_step_w+1)'(l);
    assign w_lane_vld[l] = feed_valid_d && (w_k < (c_step_w+1)'(N));

    // West lane l = A[l][k]
    assign w_a_rd_row[l*c_addr_w +: c_addr_w] = c_addr_w'(l);
    assign w_a_rd_col[l*c_addr_w +: c_addr_w] = w_k[c_addr_w-1:0];

`ifdef SYSTOLIC_SKEW_FEEDER_TRANSPOSE_B_EN
    // North lane l = B[l][k] (bank holds B transposed)
    assign w_b_rd_row[l*c_addr_w +: c_addr_w] = c_addr_w'(l);
    assign w_b_rd_col[l*c_addr_w +: c_addr_w] = w_k[c_addr_w-1:0];
`else
    // North lane l = B[k][l]
    assign w_b_rd_row[l*c_addr_w +: c_addr_w] = w_k[c_addr_w-1:0];
    assign w_b_rd_col[l*c_addr_w +: c_addr_w] = c_addr_w'(l);
`endif
  end

  // ------------------------------------------------------------- banks
  operand_bank #(
    .N  (N),
    .DW (DW)
  ) u_a_bank (
    .clk      (clk),
    .wr_en    (w_a_we),
    .wr_row   (wr_row),
    .wr_col   (wr_col),
    .wr_data  (wr_data),
    .rd_row   (w_a_rd_row),
    .rd_col   (w_a_rd_col),
    .rd_valid (w_lane_vld),
    .rd_data  (w_a_rd_data)
  );

  operand_bank #(
    .N  (N),
    .DW (DW)
  ) u_b_bank (
    .clk      (clk),
    .wr_en    (w_b_we),
    .wr_row   (wr_row),
    .wr_col   (wr_col),
    .wr_data  (wr_data),
    .rd_row   (w_b_rd_row),
    .rd_col   (w_b_rd_col),
    .rd_valid (w_lane_vld),
    .rd_data  (w_b_rd_data)
  );

  // --------------------------------------------------------- registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      step_q       <= '0;
      busy_q       <= 1'b0;
      wr_err_q     <= 1'b0;
      arr_clr_q    <= 1'b0;
      feed_valid_q <= 1'b0;
      done_q       <= 1'b0;
      west_q       <= '0;
      north_q      <= '0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      busy_q       <= busy_d;
      wr_err_q     <= wr_err_d;
      arr_clr_q    <= arr_clr_d;
      feed_valid_q <= feed_valid_d;
      done_q       <= done_d;
      west_q       <= west_d;
      north_q      <= north_d;
    end
  end

  assign busy       = busy_q;
  assign wr_err     = wr_err_q;
  assign arr_clr    = arr_clr_q;
  assign feed_valid = feed_valid_q;
  assign done       = done_q;
  assign west_out   = west_q;
  assign north_out  = north_q;

endmodule
`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_systolic_skew_feeder                                   |
// | Description : Directed self-checking bench for systolic_skew_feeder,    |
// |               with a behavioural 4x4 MAC array fed by the DUT outputs.  |
// | Revision    : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
module tb_systolic_skew_feeder;
  import systolic_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic         wr_sel;
  logic [1:0]   wr_row;
  logic [1:0]   wr_col;
  logic [31:0]  wr_data;
  logic         start;
  logic         busy;
  logic         wr_err;
  logic         arr_clr;
  logic         feed_valid;
  logic [127:0] west_out;
  logic [127:0] north_out;
  logic         done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  systolic_skew_feeder #(
    .N            (4),
    .DW           (32),
    .DRAIN_CYCLES (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_row     (wr_row),
    .wr_col     (wr_col),
    .wr_data    (wr_data),
    .start      (start),
    .busy       (busy),
    .wr_err     (wr_err),
    .arr_clr    (arr_clr),
    .feed_valid (feed_valid),
    .west_out   (west_out),
    .north_out  (north_out),
    .done       (done)
  );

  // Behavioural output-stationary array: A flows east, B flows south.
  logic [31:0] pa_q  [4][4];
  logic [31:0] pb_q  [4][4];
  logic [31:0] acc_q [4][4];

  always @(posedge clk or posedge rst) begin : array_model
    logic [31:0] a_in;
    logic [31:0] b_in;
    if (rst || arr_clr) begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          pa_q[i][j]  <= '0;
          pb_q[i][j]  <= '0;
          acc_q[i][j] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          a_in = (j == 0) ? lane_slice(west_out, i)  : pa_q[i][(j == 0) ? 0 : j-1];
          b_in = (i == 0) ? lane_slice(north_out, j) : pb_q[(i == 0) ? 0 : i-1][j];
          acc_q[i][j] <= acc_q[i][j] + a_in * b_in;
          pa_q[i][j]  <= a_in;
          pb_q[i][j]  <= b_in;
        end
      end
    end
  end

  // Expected wavefronts for A[i][k] = 10*i+k and B[k][j] = 100*k+j.
  function automatic logic [127:0] exp_west(input int t);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 4; i++)
      if (t - i >= 0 && t - i < 4) v[i*32 +: 32] = 32'(10*i + (t - i));
    return v;
  endfunction

  function automatic logic [127:0] exp_north(input int t);
    logic [127:0] v;
    v = '0;
    for (int j = 0; j < 4; j++)
      if (t - j >= 0 && t - j < 4) v[j*32 +: 32] = 32'(100*(t - j) + j);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic sel, input int row, input int col,
                            input logic [31:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_row  = 2'(row);
    wr_col  = 2'(col);
    wr_data = data;
    tick();
    wr_en   = 1'b0;
  endtask

  // B is written transposed when the feeder reads it transposed, so the
  // north stream must come out the same either way.
  task automatic load_stream_ops();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++)
        write_word(SEL_A, i, k, 32'(10*i + k));
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++)
`ifdef SYSTOLIC_SKEW_FEEDER_TRANSPOSE_B_EN
        write_word(SEL_B, j, k, 32'(100*k + j));
`else
        write_word(SEL_B, k, j, 32'(100*k + j));
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else pass_cnt++;
    total_cnt++; if (arr_clr !== 1'b0) $display("FAIL reset_arr_clr: got %b expected 0", arr_clr); else pass_cnt++;
    total_cnt++; if (feed_valid !== 1'b0) $display("FAIL reset_feed_valid: got %b expected 0", feed_valid); else pass_cnt++;
    total_cnt++; if (wr_err !== 1'b0) $display("FAIL reset_wr_err: got %b expected 0", wr_err); else pass_cnt++;
    total_cnt++; if (west_out !== 128'd0) $display("FAIL reset_west: got %h expected 0", west_out); else pass_cnt++;
    total_cnt++; if (north_out !== 128'd0) $display("FAIL reset_north: got %h expected 0", north_out); else pass_cnt++;
  endtask

  task automatic test_stream();
    int first_done = -1;
    int done_cnt   = 0;
    int clr_cnt    = 0;
    int fv_cnt     = 0;
    logic [31:0] exp_c;
    load_stream_ops();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (arr_clr === 1'b1) clr_cnt++;
      if (feed_valid === 1'b1) fv_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        if (first_done < 0) first_done = cyc;
      end
      if (cyc == 1) begin
        total_cnt++; if (arr_clr !== 1'b1) $display("FAIL stream_clr_c1: got %b expected 1", arr_clr); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL stream_busy_c1: got %b expected 1", busy); else pass_cnt++;
        total_cnt++; if (west_out !== 128'd0) $display("FAIL stream_west_clr: got %h expected 0", west_out); else pass_cnt++;
      end
      if (cyc >= 2 && cyc <= 8) begin
        total_cnt++;
        if (west_out !== exp_west(cyc - 2))
          $display("FAIL stream_west t=%0d: got %h expected %h", cyc - 2, west_out, exp_west(cyc - 2));
        else pass_cnt++;
        total_cnt++;
        if (north_out !== exp_north(cyc - 2))
          $display("FAIL stream_north t=%0d: got %h expected %h", cyc - 2, north_out, exp_north(cyc - 2));
        else pass_cnt++;
      end
      if (cyc == 5) begin
        total_cnt++; if (lane_slice(west_out, 3) !== 32'd30) $display("FAIL stream_t3_west3: got %0d expected 30", lane_slice(west_out, 3)); else pass_cnt++;
        total_cnt++; if (lane_slice(north_out, 3) !== 32'd3) $display("FAIL stream_t3_north3: got %0d expected 3", lane_slice(north_out, 3)); else pass_cnt++;
      end
      if (cyc == 8) begin
        total_cnt++; if (west_out !== {32'd33, 96'd0}) $display("FAIL stream_t6_west: got %h expected lane3=33 only", west_out); else pass_cnt++;
        total_cnt++; if (north_out !== {32'd303, 96'd0}) $display("FAIL stream_t6_north: got %h expected lane3=303 only", north_out); else pass_cnt++;
      end
      if (cyc == 13) begin
        total_cnt++; if (busy !== 1'b1) $display("FAIL stream_busy_c13: got %b expected 1", busy); else pass_cnt++;
      end
      if (cyc == 14) begin
        total_cnt++; if (busy !== 1'b0) $display("FAIL stream_busy_c14: got %b expected 0", busy); else pass_cnt++;
      end
      tick();
    end
    total_cnt++; if (clr_cnt !== 1) $display("FAIL stream_clr_count: got %0d expected 1", clr_cnt); else pass_cnt++;
    total_cnt++; if (fv_cnt !== 7) $display("FAIL stream_feed_count: got %0d expected 7", fv_cnt); else pass_cnt++;
    total_cnt++; if (done_cnt !== 1) $display("FAIL stream_done_count: got %0d expected 1", done_cnt); else pass_cnt++;
    total_cnt++; if (first_done !== 14) $display("FAIL stream_done_cycle: got %0d expected 14", first_done); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        exp_c = '0;
        for (int k = 0; k < 4; k++) exp_c = exp_c + 32'((10*i + k) * (100*k + j));
        total_cnt++;
        if (acc_q[i][j] !== exp_c)
          $display("FAIL stream_array C[%0d][%0d]: got %0d expected %0d", i, j, acc_q[i][j], exp_c);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_wr_err_and_back_to_back();
    int done_cnt = 0;
    int bad      = 0;
    int n        = 0;
    // Identity A, all-ones B; B[3][3] is written in the same cycle as start.
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++)
        write_word(SEL_A, i, k, (i == k) ? 32'd1 : 32'd0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!(r == 3 && c == 3)) write_word(SEL_B, r, c, 32'd1);
    wr_en = 1'b1; wr_sel = SEL_B; wr_row = 2'd3; wr_col = 2'd3; wr_data = 32'd1;
    start = 1'b1;
    tick();                                   // cycle 1 (CLEAR)
    wr_en = 1'b0;
    start = 1'b0;
    tick();                                   // cycle 2 (t=0)
    tick();                                   // cycle 3 (t=1)
    wr_en = 1'b1; wr_sel = SEL_A; wr_row = 2'd0; wr_col = 2'd0; wr_data = 32'hDEADBEEF;
    tick();                                   // cycle 4
    wr_en = 1'b0;
    total_cnt++; if (wr_err !== 1'b1) $display("FAIL wr_err_pulse: got %b expected 1", wr_err); else pass_cnt++;
    tick();                                   // cycle 5
    total_cnt++; if (wr_err !== 1'b0) $display("FAIL wr_err_single: got %b expected 0", wr_err); else pass_cnt++;
    repeat (5) tick();                        // cycle 10 (DRAIN)
    start = 1'b1;
    tick();                                   // cycle 11
    start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (done === 1'b1) done_cnt++;
      tick();
    end
    total_cnt++; if (done_cnt !== 1) $display("FAIL drain_start_ignored: got %0d done pulses expected 1", done_cnt); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL drain_start_busy: got %b expected 0", busy); else pass_cnt++;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (acc_q[i][j] !== 32'd1) bad++;
    total_cnt++; if (bad !== 0) $display("FAIL ident_ones_run1: got %0d wrong entries expected 0", bad); else pass_cnt++;
    // Rerun: the dropped 0xDEADBEEF write must not have reached A.
    start = 1'b1;
    tick();
    start = 1'b0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    total_cnt++; if (done !== 1'b1) $display("FAIL rerun_done_timeout: got %b expected 1 within 40 cycles", done); else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (acc_q[i][j] !== 32'd1) bad++;
    total_cnt++; if (bad !== 0) $display("FAIL ident_ones_run2: got %0d wrong entries expected 0", bad); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid();
    int done_cnt = 0;
    load_stream_ops();
    start = 1'b1;
    tick();                                   // cycle 1
    start = 1'b0;
    repeat (4) tick();                        // cycle 5 = FEED t=3
    total_cnt++; if (west_out !== exp_west(3)) $display("FAIL mid_pre_west: got %h expected %h", west_out, exp_west(3)); else pass_cnt++;
    total_cnt++; if (north_out !== exp_north(3)) $display("FAIL mid_pre_north: got %h expected %h", north_out, exp_north(3)); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL mid_async_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (west_out !== 128'd0) $display("FAIL mid_async_west: got %h expected 0", west_out); else pass_cnt++;
    total_cnt++; if (north_out !== 128'd0) $display("FAIL mid_async_north: got %h expected 0", north_out); else pass_cnt++;
    total_cnt++; if (feed_valid !== 1'b0) $display("FAIL mid_async_valid: got %b expected 0", feed_valid); else pass_cnt++;
    tick();
    total_cnt++; if (busy !== 1'b0) $display("FAIL mid_next_busy: got %b expected 0", busy); else pass_cnt++;
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done === 1'b1) done_cnt++;
      tick();
    end
    total_cnt++; if (done_cnt !== 0) $display("FAIL mid_no_done: got %0d done pulses expected 0", done_cnt); else pass_cnt++;
    // Restart: banks kept their contents, so the wavefronts repeat.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();                                   // FEED t=0
    for (int t = 0; t < 7; t++) begin
      total_cnt++;
      if (west_out !== exp_west(t))
        $display("FAIL restart_west t=%0d: got %h expected %h", t, west_out, exp_west(t));
      else pass_cnt++;
      total_cnt++;
      if (north_out !== exp_north(t))
        $display("FAIL restart_north t=%0d: got %h expected %h", t, north_out, exp_north(t));
      else pass_cnt++;
      tick();
    end
    repeat (10) tick();
  endtask

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_sel  = 1'b0;
    wr_row  = 2'd0;
    wr_col  = 2'd0;
    wr_data = 32'd0;
    start   = 1'b0;
    test_reset();
    test_stream();
    test_wr_err_and_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
